// File: rtl/axis_xn_if.sv
// Axis_If: valid/ready stream bundle shared by the axis_xn ports.
//   valid  : producer has a beat on data/last
//   ready  : consumer accepts the beat this cycle
//   data   : DWIDTH-bit payload
//   last   : end-of-packet marker, travels with its beat
// Modports: master drives valid/data/last, slave drives ready.
interface Axis_If #(
    parameter int DWIDTH = 32
);
    logic              valid;
    logic              ready;
    logic [DWIDTH-1:0] data;
    logic              last;

    modport master (output valid, output data, output last, input ready);
    modport slave  (input valid, input data, input last, output ready);
endinterface

// File: rtl/axis_xn.sv
// axis_xn: elastic per-sample arithmetic on a valid/ready stream.
// Each beat carries PARALLEL_SAMPLES signed samples of SAMPLE_WIDTH bits.
// The mode sampled with a beat selects the operation for that beat only:
//   0 pass, 1 square (top half of the full product), 2 abs, 3 negate.
// The result is computed at the input and then rides a PIPE_STAGES-deep
// elastic register chain, so latency with no backpressure is PIPE_STAGES.
//
// Ports:
//   clk      : clock
//   reset    : synchronous, active-high
//   mode     : 2-bit operation select, captured with each accepted beat
//   data_in  : Axis_If slave, input beats
//   data_out : Axis_If master, result beats
//   busy     : any pipeline stage holds a valid beat
//
// Build option: define AXIS_XN_SAT_EN to make abs/negate of the most
// negative sample saturate to the most positive value; otherwise it wraps
// back to the most negative value.

// Per-sample datapath, purely combinational.
module axis_xn_lane #(
    parameter int W = 16
) (
    input  logic [W-1:0] x_i,
    input  logic [1:0]   mode_i,
    output logic [W-1:0] y_o
);
    localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};
`ifdef AXIS_XN_SAT_EN
    localparam logic [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};
    localparam logic [W-1:0] MOST_POS = ~MOST_NEG;
`endif

    logic [2*W-1:0] x_ext;
    logic [W-1:0]   sq_hi;
    logic [W-1:0]   neg;
    logic [W-1:0]   neg_fix;

    always_comb begin
        // Sign-extend to 2W so the low 2W bits of the unsigned product equal
        // the signed square; keep only the upper W bits (truncation).
        x_ext = {{W{x_i[W-1]}}, x_i};
        sq_hi = W'((x_ext * x_ext) >> W);
        neg   = ~x_i + ONE;
`ifdef AXIS_XN_SAT_EN
        neg_fix = (x_i == MOST_NEG) ? MOST_POS : neg;
`else
        neg_fix = neg;
`endif
        case (mode_i)
            2'd0:    y_o = x_i;
            2'd1:    y_o = sq_hi;
            2'd2:    y_o = x_i[W-1] ? neg_fix : x_i;
            default: y_o = neg_fix;
        endcase
    end
endmodule

module axis_xn #(
    parameter int SAMPLE_WIDTH     = 16,
    parameter int PARALLEL_SAMPLES = 2,
    parameter int SAMPLE_FRAC_BITS = 14,
    parameter int PIPE_STAGES      = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] mode,
    Axis_If.slave      data_in,
    Axis_If.master     data_out,
    output logic       busy
);
    localparam int DW = SAMPLE_WIDTH * PARALLEL_SAMPLES;

    generate
        if (PIPE_STAGES < 1 || PIPE_STAGES > 8) begin : g_bad_stages
            $error("axis_xn: PIPE_STAGES must be 1..8");
        end
        if (SAMPLE_FRAC_BITS < 0 || SAMPLE_FRAC_BITS >= SAMPLE_WIDTH) begin : g_bad_frac
            $error("axis_xn: SAMPLE_FRAC_BITS must be 0..SAMPLE_WIDTH-1");
        end
    endgenerate

    // Result of the beat currently offered on data_in.
    logic [DW-1:0] res;

    for (genvar i = 0; i < PARALLEL_SAMPLES; i++) begin : g_lane
        axis_xn_lane #(.W(SAMPLE_WIDTH)) u_lane (
            .x_i    (data_in.data[i*SAMPLE_WIDTH +: SAMPLE_WIDTH]),
            .mode_i (mode),
            .y_o    (res[i*SAMPLE_WIDTH +: SAMPLE_WIDTH])
        );
    end

    logic [PIPE_STAGES-1:0]         vld_q,  vld_d;
    logic [PIPE_STAGES-1:0]         last_q, last_d;
    logic [PIPE_STAGES-1:0][DW-1:0] data_q, data_d;

    // ld[k]: stage k may load this cycle. ld[PIPE_STAGES] is the sink.
    // A stage loads when empty or when its own content moves on, which
    // reduces to ~vld | ld[k+1].
    logic [PIPE_STAGES:0] ld;

    always_comb begin
        ld = '0;
        ld[PIPE_STAGES] = data_out.ready;
        for (int k = PIPE_STAGES - 1; k >= 0; k--) begin
            ld[k] = ~vld_q[k] | ld[k+1];
        end
    end

    always_comb begin
        vld_d  = vld_q;
        last_d = last_q;
        data_d = data_q;
        if (ld[0]) begin
            vld_d[0] = data_in.valid;
            if (data_in.valid) begin
                data_d[0] = res;
                last_d[0] = data_in.last;
            end
        end
        for (int k = 1; k < PIPE_STAGES; k++) begin
            if (ld[k]) begin
                vld_d[k] = vld_q[k-1];
                // Payload only moves with a real beat; bubbles leave it be.
                if (vld_q[k-1]) begin
                    data_d[k] = data_q[k-1];
                    last_d[k] = last_q[k-1];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_q  <= '0;
            last_q <= '0;
            data_q <= '0;
        end else begin
            vld_q  <= vld_d;
            last_q <= last_d;
            data_q <= data_d;
        end
    end

    assign data_in.ready  = ld[0] & ~reset;
    assign data_out.valid = vld_q[PIPE_STAGES-1];
    assign data_out.data  = data_q[PIPE_STAGES-1];
    assign data_out.last  = last_q[PIPE_STAGES-1];
    assign busy           = |vld_q;
endmodule

// File: tb/tb_axis_xn.sv
module tb_axis_xn;
    localparam int DW = 32;
    localparam int NS = 3;
`ifdef AXIS_XN_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic       clk    = 1'b0;
    logic       reset  = 1'b1;
    logic [1:0] mode_r = 2'd0;
    logic       busy;

    Axis_If #(.DWIDTH(DW)) in_if ();
    Axis_If #(.DWIDTH(DW)) out_if ();

    axis_xn #(
        .SAMPLE_WIDTH     (16),
        .PARALLEL_SAMPLES (2),
        .SAMPLE_FRAC_BITS (14),
        .PIPE_STAGES      (NS)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .mode     (mode_r),
        .data_in  (in_if),
        .data_out (out_if),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Reference: integer arithmetic on the signed sample value.
    function automatic logic [15:0] ref_lane(input logic [15:0] x, input logic [1:0] m);
        int v, r;
        v = $signed(x);
        case (m)
            2'd0:    r = v;
            2'd1:    r = (v * v) >>> 16;
            2'd2:    r = (v < 0) ? -v : v;
            default: r = -v;
        endcase
        if (r == 32768) r = SAT ? 32767 : -32768;
        return r[15:0];
    endfunction

    function automatic logic [31:0] ref_beat(input logic [31:0] d, input logic [1:0] m);
        return {ref_lane(d[31:16], m), ref_lane(d[15:0], m)};
    endfunction

    // Scoreboard and output log, sampled on the falling edge.
    logic [32:0] exp_q[$];
    logic [32:0] out_log[$];
    int          acc_cnt = 0;
    int          out_cnt = 0;
    logic        stall_prev = 1'b0;
    logic [32:0] stall_val  = '0;

    always @(negedge clk) begin
        logic [32:0] e;
        if (reset) begin
            exp_q.delete();
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                chk("hold_valid", 32'(out_if.valid), 32'd1);
                chk("hold_data", out_if.data, stall_val[31:0]);
                chk("hold_last", 32'(out_if.last), 32'(stall_val[32]));
            end
            if (in_if.valid && in_if.ready) begin
                exp_q.push_back({in_if.last, ref_beat(in_if.data, mode_r)});
                acc_cnt++;
            end
            if (out_if.valid && out_if.ready) begin
                out_cnt++;
                out_log.push_back({out_if.last, out_if.data});
                if (exp_q.size() == 0) begin
                    chk("spurious_out", 32'(out_if.valid), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_data", out_if.data, e[31:0]);
                    chk("sb_last", 32'(out_if.last), 32'(e[32]));
                end
            end
            stall_prev = out_if.valid && !out_if.ready;
            stall_val  = {out_if.last, out_if.data};
        end
    end

    logic [31:0] ms_exp [4] = '{32'h0003_0001, 32'h0000_0000, 32'h0003_0001, 32'hFFFD_FFFF};
    logic [31:0] bp_dat [5] = '{32'h1111_A001, 32'h2222_B002, 32'h3333_C003, 32'h4444_D004, 32'h5555_E005};
    logic        bp_last[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

    initial begin
        int a0, o0, idx;
        logic [31:0] sat_exp;

        in_if.valid  = 1'b0;
        in_if.data   = '0;
        in_if.last   = 1'b0;
        out_if.ready = 1'b1;

        // Reset state
        repeat (3) step();
        chk("rst_out_valid", 32'(out_if.valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_out_data", out_if.data, 32'd0);
        chk("rst_out_last", 32'(out_if.last), 32'd0);
        chk("rst_in_ready", 32'(in_if.ready), 32'd0);
        reset = 1'b0;
        #1;
        chk("rdy_after_rst", 32'(in_if.ready), 32'd1);

        // Latency: square of {0x8000,0x4000} offered in cycle t, output in t+3
        mode_r      = 2'd1;
        in_if.valid = 1'b1;
        in_if.data  = 32'h8000_4000;
        in_if.last  = 1'b1;
        step();
        in_if.valid = 1'b0;
        in_if.last  = 1'b0;
        chk("lat_t1_valid", 32'(out_if.valid), 32'd0);
        step();
        chk("lat_t2_valid", 32'(out_if.valid), 32'd0);
        step();
        chk("lat_t3_valid", 32'(out_if.valid), 32'd1);
        chk("lat_t3_data", out_if.data, 32'h4000_1000);
        chk("lat_t3_last", 32'(out_if.last), 32'd1);
        step();
        chk("lat_t4_valid", 32'(out_if.valid), 32'd0);

        // Mode switching, one beat per cycle
        out_log.delete();
        in_if.valid = 1'b1;
        in_if.data  = 32'h0003_0001;
        for (int m = 0; m < 4; m++) begin
            mode_r = 2'(m);
            step();
        end
        in_if.valid = 1'b0;
        repeat (6) step();
        chk("ms_count", out_log.size(), 32'd4);
        for (int i = 0; i < 4 && i < out_log.size(); i++)
            chk("ms_data", out_log[i][31:0], ms_exp[i]);

        // Saturation of the most negative value, plus ordinary abs/negate
        out_log.delete();
        sat_exp = SAT ? 32'h7FFF_7FFF : 32'h8000_8000;
        in_if.valid = 1'b1;
        mode_r = 2'd2; in_if.data = 32'h8000_8000; step();
        mode_r = 2'd3; in_if.data = 32'h8000_8000; step();
        mode_r = 2'd2; in_if.data = 32'h7FFF_FFFF; step();
        mode_r = 2'd3; in_if.data = 32'h0001_7FFF; step();
        in_if.valid = 1'b0;
        repeat (6) step();
        chk("sat_count", out_log.size(), 32'd4);
        if (out_log.size() == 4) begin
            chk("sat_abs_min", out_log[0][31:0], sat_exp);
            chk("sat_neg_min", out_log[1][31:0], sat_exp);
            chk("abs_plain", out_log[2][31:0], 32'h7FFF_0001);
            chk("neg_plain", out_log[3][31:0], 32'hFFFF_8001);
        end

        // Backpressure: sink stalled for 10 cycles
        out_log.delete();
        mode_r       = 2'd0;
        out_if.ready = 1'b0;
        a0  = acc_cnt;
        idx = 0;
        in_if.valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            in_if.data = bp_dat[idx];
            in_if.last = bp_last[idx];
            @(negedge clk);
            if (in_if.ready && idx < 4) idx++;
            step();
        end
        chk("bp_accepted", acc_cnt - a0, 32'd3);
        chk("bp_in_ready", 32'(in_if.ready), 32'd0);
        chk("bp_busy", 32'(busy), 32'd1);
        in_if.valid  = 1'b0;
        out_if.ready = 1'b1;
        repeat (6) step();
        chk("bp_count", out_log.size(), 32'd3);
        for (int i = 0; i < 3 && i < out_log.size(); i++) begin
            chk("bp_data", out_log[i][31:0], bp_dat[i]);
            chk("bp_last", 32'(out_log[i][32]), 32'(bp_last[i]));
        end

        // Random traffic against the reference model
        a0 = acc_cnt;
        o0 = out_cnt;
        for (int c = 0; c < 2000; c++) begin
            in_if.valid  = 1'($urandom_range(0, 1));
            in_if.data   = $urandom;
            in_if.last   = 1'($urandom_range(0, 1));
            mode_r       = 2'($urandom_range(0, 3));
            out_if.ready = ($urandom_range(0, 3) != 0);
            step();
        end
        in_if.valid  = 1'b0;
        out_if.ready = 1'b1;
        repeat (10) step();
        chk("rand_count", out_cnt - o0, acc_cnt - a0);
        chk("rand_drained", exp_q.size(), 32'd0);

        // Reset with three beats in flight
        out_if.ready = 1'b0;
        in_if.valid  = 1'b1;
        in_if.data   = 32'hDEAD_BEEF;
        repeat (4) step();
        in_if.valid = 1'b0;
        chk("mid_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        step();
        chk("mid_rst_valid", 32'(out_if.valid), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        o0 = out_cnt;
        out_if.ready = 1'b1;
        repeat (8) step();
        chk("mid_no_stale", out_cnt - o0, 32'd0);
        chk("mid_out_valid", 32'(out_if.valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/axis_xn.md
AXIS_XN -- requirements
Module: axis_xn

Interface
REQ-001 The block SHALL have parameter SAMPLE_WIDTH, default 16, meaning bits per signed sample.
REQ-002 The block SHALL have parameter PARALLEL_SAMPLES, default 2, meaning samples per beat.
REQ-003 The block SHALL have parameter SAMPLE_FRAC_BITS, default 14, meaning input fractional bits.
REQ-004 The block SHALL have parameter PIPE_STAGES, default 3 (legal range 1..8), meaning register stages.
REQ-005 The block SHALL have port clk, input, 1 bit: clock.
REQ-006 The block SHALL have port reset, input, 1 bit: reset, synchronous, active-high.
REQ-007 The block SHALL have port mode, input, 2 bits: operation select, 0 pass, 1 square, 2 abs, 3 negate.
REQ-008 The block SHALL have port data_in, Axis_If slave, DWIDTH=SAMPLE_WIDTH*PARALLEL_SAMPLES: input beats, carrying valid, ready, data and last.
REQ-009 The block SHALL have port data_out, Axis_If master, same DWIDTH: result beats, carrying valid, ready, data and last.
REQ-010 The block SHALL have port busy, output, 1 bit: high while any pipeline stage holds a valid beat.

Function
REQ-011 Sample i SHALL occupy data[i*SAMPLE_WIDTH +: SAMPLE_WIDTH], two's complement, in both data_in and data_out.
REQ-012 The block SHALL capture mode together with each beat on data_in.valid && data_in.ready, and SHALL apply it to that beat only; mode changes SHALL be beat-exact.
REQ-013 Pass mode SHALL output y = x.
REQ-014 Square mode SHALL form the full 2*SAMPLE_WIDTH-bit product p = x*x and output y = p[2*SAMPLE_WIDTH-1 : SAMPLE_WIDTH] (truncation, no rounding). The output format has 2*(SAMPLE_WIDTH-SAMPLE_FRAC_BITS) integer bits, and the result SHALL never overflow.
REQ-015 Abs mode SHALL output y = |x|, and negate mode SHALL output y = -x; REQ-026/027 govern the x = most-negative case.
REQ-016 data_in.last SHALL travel with its beat and appear unchanged on data_out.last.
REQ-017 The pipeline SHALL be elastic: stage k loads when it is empty or when its content advances to stage k+1 (or to the output) in the same cycle.
REQ-018 data_in.ready SHALL equal (stage 0 empty) OR (stage 0 advancing); a combinational ready path from data_out.ready is permitted.
REQ-019 With data_out.ready held high, a beat accepted at cycle t SHALL appear with data_out.valid at cycle t+PIPE_STAGES, at a throughput of one beat per cycle.
REQ-020 With data_out.ready low, the block SHALL accept up to PIPE_STAGES beats, then deassert data_in.ready; no beat SHALL be lost, duplicated or reordered.
REQ-021 data_out.valid, data and last SHALL remain stable while data_out.valid is high and data_out.ready is low.
REQ-022 Simultaneous input accept and output transfer in a full pipeline SHALL shift all stages in the same cycle.

Reset
REQ-023 While reset is high, all stage valid bits, data_out.valid and busy SHALL be 0 on the next clk edge, and data_out.data and data_out.last SHALL be 0.
REQ-024 Reset asserted mid-stream SHALL discard all in-flight beats, with no partial output after release.
REQ-025 data_in.ready SHALL be 0 during reset and SHALL rise in the first cycle after reset deasserts.

Configuration
REQ-026 With macro AXIS_XN_SAT_EN defined, abs and negate of the most-negative value SHALL saturate to the most-positive value (0x7FFF for width 16).
REQ-027 Without AXIS_XN_SAT_EN, abs and negate of the most-negative value SHALL wrap to the most-negative value (0x8000); all other results SHALL be identical with and without the macro.

Verification (SAMPLE_WIDTH=16, PARALLEL_SAMPLES=2, SAMPLE_FRAC_BITS=14, PIPE_STAGES=3)
REQ-028 Latency: mode=1, a single beat {0x4000,0x8000}, ready=1 -> {0x1000,0x4000} with data_out.valid exactly 3 cycles after acceptance.
REQ-029 Mode switching: beats {0x0001,0x0003} sent with mode 0,1,2,3 on consecutive cycles -> outputs {0x0001,0x0003}, {0x0000,0x0000}, {0x0001,0x0003}, {0xFFFF,0xFFFD} in order.
REQ-030 Saturation: mode=2 and mode=3 on 0x8000 -> 0x7FFF with AXIS_XN_SAT_EN, 0x8000 without it.
REQ-031 Backpressure: valid=1 and data_out.ready=0 for 10 cycles -> exactly 3 beats accepted, data_in.ready low thereafter; after ready=1, all 3 beats emerge in order with last preserved.
REQ-032 Random: 2000 cycles of random valid/ready and mode with full-range random data -> every output matches the reference model exactly, and output count equals accepted count.
REQ-033 Reset: reset asserted with 3 beats in flight -> data_out.valid=0 and busy=0 on the next edge, and no stale beats after release.
